// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the control sequencer.
// T6 exists only when CU_MULDIV_EN is defined.
package cu_pkg;

   `ifdef CU_MULDIV_EN
   typedef enum logic [3:0] {
      IDLE, T0, T1, T2, T3, T4, T5, T6, HALT
   } state_e;
   `else
   typedef enum logic [3:0] {
      IDLE, T0, T1, T2, T3, T4, T5, HALT
   } state_e;
   `endif

   localparam logic [4:0] OPC_ALU_MAX = 5'h0B;
   localparam logic [4:0] OPC_MUL     = 5'h0F;
   localparam logic [4:0] OPC_DIV     = 5'h10;
   localparam logic [4:0] OPC_NOP     = 5'h1A;
   localparam logic [4:0] OPC_HALT    = 5'h1B;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;

endpackage

// File: rtl/control_sequencer_if.sv
// Control-strobe bundle between the sequencer and the datapath.
// master = sequencer side, slave = datapath side.
interface control_sequencer_if #(
   parameter int NUM_REGS = 16,
   parameter int OPW      = 5
);
   logic                run;
   logic [31:0]         IR;
   logic [NUM_REGS-1:0] R_rd;
   logic [NUM_REGS-1:0] R_wrt;
   logic PC_out, MDR_out, Zlo_out;
   logic Zhi_out, HI_out, LO_out;
   logic PC_rd, MAR_rd, MDR_rd, IR_rd, Y_rd;
   logic Zlo_rd, Zhi_rd, HI_rd, LO_rd;
   logic IncPC, Read;
   logic [OPW-1:0]      op_sel;
   logic busy, halted;

   modport master (
      input  run, IR,
      output R_rd, R_wrt,
      output PC_out, MDR_out, Zlo_out,
      output Zhi_out, HI_out, LO_out,
      output PC_rd, MAR_rd, MDR_rd, IR_rd, Y_rd,
      output Zlo_rd, Zhi_rd, HI_rd, LO_rd,
      output IncPC, Read, op_sel, busy, halted
   );

   modport slave (
      output run, IR,
      input  R_rd, R_wrt,
      input  PC_out, MDR_out, Zlo_out,
      input  Zhi_out, HI_out, LO_out,
      input  PC_rd, MAR_rd, MDR_rd, IR_rd, Y_rd,
      input  Zlo_rd, Zhi_rd, HI_rd, LO_rd,
      input  IncPC, Read, op_sel, busy, halted
   );
endinterface

// File: rtl/control_sequencer_reg_onehot_dec.sv
// 4-bit register index to one-hot select vector.
// Indices at or beyond NUM_REGS match no bit, so the vector stays zero.
module reg_onehot_dec #(
   parameter int NUM_REGS = 16
) (
   input  logic [3:0]          idx_i,
   output logic [NUM_REGS-1:0] onehot_o
);

   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (int'(idx_i) == i) onehot_o[i] = 1'b1;
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Hard-wired Moore control unit: fetch/decode/execute, one T-step per clk.
// Define CU_MULDIV_EN to enable MUL/DIV and the T6 step.
module control_sequencer
   import cu_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int OPW      = 5
) (
   input  logic                 clk,
   input  logic                 clr,
   control_sequencer_if.master  cu
);

   state_e state_q, state_d;
   state_e fin;

   logic [4:0] opc;
   logic [3:0] ra, rb, rc;
   logic       is_alu, is_md;
   logic       unused_ir;

   logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;

   assign opc = cu.IR[OPC_MSB:OPC_LSB];
   assign ra  = cu.IR[RA_MSB:RA_LSB];
   assign rb  = cu.IR[RB_MSB:RB_LSB];
   assign rc  = cu.IR[RC_MSB:RC_LSB];
   assign unused_ir = ^cu.IR[RC_LSB-1:0];

   assign is_alu = (opc <= OPC_ALU_MAX);
   `ifdef CU_MULDIV_EN
   assign is_md = (opc == OPC_MUL) || (opc == OPC_DIV);
   `else
   assign is_md = 1'b0;
   `endif

   // End-of-instruction: chain straight into the next fetch while run holds.
   assign fin = cu.run ? T0 : IDLE;

   reg_onehot_dec #(.NUM_REGS(NUM_REGS)) u_dec_ra (
      .idx_i    (ra),
      .onehot_o (ra_oh)
   );

   reg_onehot_dec #(.NUM_REGS(NUM_REGS)) u_dec_rb (
      .idx_i    (rb),
      .onehot_o (rb_oh)
   );

   reg_onehot_dec #(.NUM_REGS(NUM_REGS)) u_dec_rc (
      .idx_i    (rc),
      .onehot_o (rc_oh)
   );

   always_ff @(posedge clk) begin
      if (clr) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (cu.run) state_d = T0;
         T0:   state_d = T1;
         T1:   state_d = T2;
         T2: begin
            unique case (1'b1)
               is_alu || is_md:  state_d = T3;
               opc == OPC_NOP:   state_d = fin;
               opc == OPC_HALT:  state_d = HALT;
               default:          state_d = HALT;
            endcase
         end
         T3:   state_d = T4;
         T4:   state_d = T5;
         `ifdef CU_MULDIV_EN
         T5:   state_d = is_md ? T6 : fin;
         T6:   state_d = fin;
         `else
         T5:   state_d = fin;
         `endif
         HALT: state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      cu.R_rd    = '0;
      cu.R_wrt   = '0;
      cu.PC_out  = 1'b0;
      cu.MDR_out = 1'b0;
      cu.Zlo_out = 1'b0;
      cu.Zhi_out = 1'b0;
      cu.HI_out  = 1'b0;
      cu.LO_out  = 1'b0;
      cu.PC_rd   = 1'b0;
      cu.MAR_rd  = 1'b0;
      cu.MDR_rd  = 1'b0;
      cu.IR_rd   = 1'b0;
      cu.Y_rd    = 1'b0;
      cu.Zlo_rd  = 1'b0;
      cu.Zhi_rd  = 1'b0;
      cu.HI_rd   = 1'b0;
      cu.LO_rd   = 1'b0;
      cu.IncPC   = 1'b0;
      cu.Read    = 1'b0;
      cu.op_sel  = '0;
      cu.halted  = 1'b0;
      cu.busy    = (state_q != IDLE) && (state_q != HALT);
      unique case (state_q)
         T0: begin
            cu.PC_out = 1'b1;
            cu.MAR_rd = 1'b1;
            cu.IncPC  = 1'b1;
            cu.Zlo_rd = 1'b1;
         end
         T1: begin
            cu.Zlo_out = 1'b1;
            cu.PC_rd   = 1'b1;
            cu.Read    = 1'b1;
            cu.MDR_rd  = 1'b1;
         end
         T2: begin
            cu.MDR_out = 1'b1;
            cu.IR_rd   = 1'b1;
         end
         T3: begin
            cu.R_wrt = is_md ? ra_oh : rb_oh;
            cu.Y_rd  = 1'b1;
         end
         T4: begin
            cu.R_wrt  = is_md ? rb_oh : rc_oh;
            cu.op_sel = OPW'(opc);
            cu.Zlo_rd = 1'b1;
            cu.Zhi_rd = is_md;
         end
         T5: begin
            cu.Zlo_out = 1'b1;
            if (is_md) cu.LO_rd = 1'b1;
            else       cu.R_rd  = ra_oh;
         end
         `ifdef CU_MULDIV_EN
         T6: begin
            cu.Zhi_out = 1'b1;
            cu.HI_rd   = 1'b1;
         end
         `endif
         HALT: cu.halted = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed table, corner sequences, random vs model.
// Honours CU_MULDIV_EN the same way as the design.
module tb_control_sequencer;

   localparam int NR = 16;
   `ifdef CU_MULDIV_EN
   localparam bit MD = 1'b1;
   `else
   localparam bit MD = 1'b0;
   `endif

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   control_sequencer_if #(.NUM_REGS(NR), .OPW(5)) bus ();

   control_sequencer #(.NUM_REGS(NR), .OPW(5)) dut (
      .clk (clk),
      .clr (clr),
      .cu  (bus)
   );

   // src: PC MDR Zlo Zhi HI LO ; ld: PC MAR MDR IR Y Zlo Zhi HI LO
   typedef struct packed {
      logic [15:0] r_rd;
      logic [15:0] r_wrt;
      logic [5:0]  src;
      logic [8:0]  ld;
      logic        incpc;
      logic        read;
      logic [4:0]  op_sel;
      logic        busy;
      logic        halted;
   } obs_t;

   typedef struct {
      logic        c;
      logic        r;
      logic [31:0] ir;
      obs_t        e;
      string       nm;
   } vec_t;

   obs_t act;
   assign act = {bus.R_rd, bus.R_wrt,
                 {bus.PC_out, bus.MDR_out, bus.Zlo_out,
                  bus.Zhi_out, bus.HI_out, bus.LO_out},
                 {bus.PC_rd, bus.MAR_rd, bus.MDR_rd, bus.IR_rd,
                  bus.Y_rd, bus.Zlo_rd, bus.Zhi_rd, bus.HI_rd,
                  bus.LO_rd},
                 bus.IncPC, bus.Read, bus.op_sel,
                 bus.busy, bus.halted};

   int pass_n  = 0;
   int total_n = 0;

   obs_t IDL, HREC, F0, F1, F2;
   vec_t tv[$];

   obs_t mcur;
   obs_t mq[$];
   bit   need_dec;

   function automatic obs_t mk(logic [5:0] s, logic [8:0] l,
                               logic inc, logic rd,
                               logic [15:0] rr, logic [15:0] rw,
                               logic [4:0] op);
      obs_t o;
      o = '0;
      o.src = s;
      o.ld = l;
      o.incpc = inc;
      o.read = rd;
      o.r_rd = rr;
      o.r_wrt = rw;
      o.op_sel = op;
      o.busy = 1'b1;
      return o;
   endfunction

   function automatic logic [15:0] oh(int idx);
      logic [15:0] one;
      one = 16'h0001;
      if (idx < NR) return one << idx;
      return 16'h0000;
   endfunction

   task automatic check(string nm, obs_t e);
      total_n++;
      if (act === e) pass_n++;
      else $display("FAIL %s: got %h want %h", nm, act, e);
      total_n++;
      if ($onehot0({act.src, act.r_wrt})) pass_n++;
      else $display("FAIL %s_bus1hot: got src=%b wrt=%h want <=1 source",
                    nm, act.src, act.r_wrt);
   endtask

   task automatic step(logic c, logic r, logic [31:0] ir,
                       obs_t e, string nm);
      clr = c;
      bus.run = r;
      bus.IR = ir;
      @(posedge clk);
      #1;
      check(nm, e);
   endtask

   task automatic add(logic c, logic r, logic [31:0] ir,
                      obs_t e, string nm);
      vec_t v;
      v.c = c;
      v.r = r;
      v.ir = ir;
      v.e = e;
      v.nm = nm;
      tv.push_back(v);
   endtask

   // Post-fetch part of an instruction, chosen from the opcode rules.
   task automatic build_tail(logic [31:0] ir);
      logic [4:0] opc;
      int ra, rb, rc;
      opc = ir[31:27];
      ra = int'(ir[26:23]);
      rb = int'(ir[22:19]);
      rc = int'(ir[18:15]);
      if (opc <= 5'h0B) begin
         mq.push_back(mk(6'h00, 9'h010, 1'b0, 1'b0, '0, oh(rb), '0));
         mq.push_back(mk(6'h00, 9'h008, 1'b0, 1'b0, '0, oh(rc), opc));
         mq.push_back(mk(6'h08, 9'h000, 1'b0, 1'b0, oh(ra), '0, '0));
      end else if (opc == 5'h1A) begin
      end else if (MD && (opc == 5'h0F || opc == 5'h10)) begin
         mq.push_back(mk(6'h00, 9'h010, 1'b0, 1'b0, '0, oh(ra), '0));
         mq.push_back(mk(6'h00, 9'h00C, 1'b0, 1'b0, '0, oh(rb), opc));
         mq.push_back(mk(6'h08, 9'h001, 1'b0, 1'b0, '0, '0, '0));
         mq.push_back(mk(6'h04, 9'h002, 1'b0, 1'b0, '0, '0, '0));
      end else begin
         mq.push_back(HREC);
      end
   endtask

   task automatic model_step(logic c, logic r, logic [31:0] ir);
      if (c) begin
         mcur = IDL;
         mq.delete();
         need_dec = 1'b0;
         return;
      end
      if (mcur.halted) return;
      if (mq.size() == 0 && need_dec) begin
         need_dec = 1'b0;
         build_tail(ir);
      end
      if (mq.size() != 0) begin
         mcur = mq.pop_front();
         return;
      end
      if (r) begin
         mcur = F0;
         mq.push_back(F1);
         mq.push_back(F2);
         need_dec = 1'b1;
      end else begin
         mcur = IDL;
      end
   endtask

   function automatic logic [31:0] rand_ir();
      logic [4:0] opc;
      int k;
      k = int'($urandom_range(15));
      if (k <= 8 || k == 15) opc = 5'($urandom_range(11));
      else if (k == 9)  opc = 5'h0F;
      else if (k == 10) opc = 5'h10;
      else if (k <= 12) opc = 5'h1A;
      else if (k == 13) opc = 5'h1B;
      else opc = 5'($urandom);
      return {opc, 27'($urandom)};
   endfunction

   initial begin
      logic [31:0] ir_a, ir_h, ir_i, ir_n, ir_m, rir;
      logic rc, rr;
      obs_t a3, a4, a5;

      IDL = '0;
      HREC = '0;
      HREC.halted = 1'b1;
      F0 = mk(6'h20, 9'h088, 1'b1, 1'b0, '0, '0, '0);
      F1 = mk(6'h08, 9'h140, 1'b0, 1'b1, '0, '0, '0);
      F2 = mk(6'h10, 9'h020, 1'b0, 1'b0, '0, '0, '0);
      a3 = mk(6'h00, 9'h010, 1'b0, 1'b0, 16'h0000, 16'h0008, 5'h00);
      a4 = mk(6'h00, 9'h008, 1'b0, 1'b0, 16'h0000, 16'h0080, 5'h0B);
      a5 = mk(6'h08, 9'h000, 1'b0, 1'b0, 16'h0010, 16'h0000, 5'h00);

      ir_a = {5'h0B, 4'd4, 4'd3, 4'd7, 15'h0};
      ir_h = {5'h1B, 27'h0};
      ir_i = {5'h15, 4'd1, 4'd2, 4'd3, 15'h0};
      ir_n = {5'h1A, 4'd1, 4'd2, 4'd3, 15'h0};
      ir_m = {5'h0F, 4'd2, 4'd5, 4'd0, 15'h0};

      clr = 1'b1;
      bus.run = 1'b1;
      bus.IR = ir_a;

      add(1, 1, ir_a, IDL, "reset_a");
      add(1, 1, ir_a, IDL, "reset_b");
      add(0, 1, ir_a, F0, "t0");
      add(0, 1, ir_a, F1, "t1");
      add(0, 1, ir_a, F2, "t2");
      add(0, 1, ir_a, a3, "t3_rb");
      add(0, 1, ir_a, a4, "t4_rc");
      add(0, 1, ir_a, a5, "t5_ra");
      add(0, 1, ir_a, F0, "b2b_t0");
      add(0, 1, ir_a, F1, "b2b_t1");
      add(0, 1, ir_a, F2, "b2b_t2");
      add(0, 1, ir_a, a3, "b2b_t3");
      add(0, 0, ir_a, a4, "drop_t4");
      add(0, 0, ir_a, a5, "drop_t5");
      add(0, 0, ir_a, IDL, "drop_idle");
      add(0, 0, ir_a, IDL, "idle_hold");

      foreach (tv[i]) step(tv[i].c, tv[i].r, tv[i].ir, tv[i].e, tv[i].nm);

      step(0, 1, ir_h, F0, "h_t0");
      step(0, 1, ir_h, F1, "h_t1");
      step(0, 1, ir_h, F2, "h_t2");
      for (int i = 0; i < 20; i++) step(0, 1, ir_h, HREC, "halt_hold");
      step(1, 1, ir_h, IDL, "halt_clr");
      step(0, 0, ir_h, IDL, "halt_release");

      step(0, 1, ir_i, F0, "ill_t0");
      step(0, 1, ir_i, F1, "ill_t1");
      step(0, 1, ir_i, F2, "ill_t2");
      step(0, 1, ir_i, HREC, "ill_halt");
      step(1, 0, ir_i, IDL, "ill_clr");

      step(0, 1, ir_n, F0, "nop_t0");
      step(0, 1, ir_n, F1, "nop_t1");
      step(0, 1, ir_n, F2, "nop_t2");
      step(0, 1, ir_n, F0, "nop_b2b");
      step(0, 0, ir_n, F1, "nop_b_t1");
      step(0, 0, ir_n, F2, "nop_b_t2");
      step(0, 0, ir_n, IDL, "nop_end");

      step(0, 1, ir_a, F0, "c_t0");
      step(0, 1, ir_a, F1, "c_t1");
      step(0, 1, ir_a, F2, "c_t2");
      step(0, 1, ir_a, a3, "c_t3");
      step(0, 1, ir_a, a4, "c_t4");
      step(1, 1, ir_a, IDL, "clr_in_t4");
      step(0, 0, ir_a, IDL, "clr_after");

      step(0, 1, ir_m, F0, "mul_t0");
      step(0, 1, ir_m, F1, "mul_t1");
      step(0, 1, ir_m, F2, "mul_t2");
      `ifdef CU_MULDIV_EN
      step(0, 1, ir_m,
           mk(6'h00, 9'h010, 1'b0, 1'b0, 16'h0, 16'h0004, 5'h00),
           "mul_t3");
      step(0, 1, ir_m,
           mk(6'h00, 9'h00C, 1'b0, 1'b0, 16'h0, 16'h0020, 5'h0F),
           "mul_t4");
      step(0, 1, ir_m,
           mk(6'h08, 9'h001, 1'b0, 1'b0, 16'h0, 16'h0, 5'h00),
           "mul_t5_lo");
      step(0, 0, ir_m,
           mk(6'h04, 9'h002, 1'b0, 1'b0, 16'h0, 16'h0, 5'h00),
           "mul_t6_hi");
      step(0, 0, ir_m, IDL, "mul_end");
      `else
      step(0, 1, ir_m, HREC, "mul_illegal");
      step(1, 0, ir_m, IDL, "mul_clr");
      `endif

      mcur = IDL;
      mq.delete();
      need_dec = 1'b0;
      rir = rand_ir();
      step(1, 0, rir, IDL, "rand_reset");
      for (int n = 0; n < 4000; n++) begin
         rc = ($urandom_range(99) < 2);
         if (mcur.halted && $urandom_range(99) < 20) rc = 1'b1;
         rr = ($urandom_range(99) < 80);
         if (!mcur.busy || need_dec) rir = rand_ir();
         model_step(rc, rr, rir);
         step(rc, rr, rir, mcur, "rand");
      end

      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end

endmodule
